lock_countdown_timer: RTL and testbench

//  Countdown timer for the lock-breaker phase. Watches the game-state bus from the state manager.

---
 rtl/lock_countdown_timer.sv | 145 ++++++++++++++
 tb/tb_lock_countdown_timer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/lock_countdown_timer.sv
// rtl/lock_countdown_timer.sv - lock-breaker countdown timer driven by the game-state bus
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   state          game-state bus; RUN_STATE arms and runs the countdown
//   current_digit  present countdown value, START_VAL down to 0
//   flag           high once the countdown reaches 0, held while state==RUN_STATE
//   tick           one-cycle pulse on each decrement
//   running        high while the FSM is counting
//   hex            {g,f,e,d,c,b,a} 7-segment pattern for current_digit
module lock_countdown_timer #(
    parameter int          TICK_DIV       = 50000000,
    parameter int          START_VAL      = 9,
    parameter logic [3:0]  RUN_STATE      = 4'b1011,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    output logic [3:0] current_digit,
    output logic       flag,
    output logic       tick,
    output logic       running,
    output logic [6:0] hex
);

    localparam int         PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] START_D  = 4'(START_VAL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t          fsm, fsm_n;
    logic [PW-1:0] prescaler, prescaler_n;
    logic [3:0]    digit_n;
    logic          flag_n, tick_n, running_n;
    logic          armed;
    logic [6:0]    seg;

    assign armed = (state == RUN_STATE);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm           <= IDLE;
            prescaler     <= '0;
            current_digit <= START_D;
            flag          <= 1'b0;
            tick          <= 1'b0;
            running       <= 1'b0;
        end else begin
            fsm           <= fsm_n;
            prescaler     <= prescaler_n;
            current_digit <= digit_n;
            flag          <= flag_n;
            tick          <= tick_n;
            running       <= running_n;
        end
    end

    always_comb begin
        fsm_n       = fsm;
        prescaler_n = prescaler;
        digit_n     = current_digit;
        flag_n      = flag;
        tick_n      = 1'b0;
        case (fsm)
            IDLE: begin
                digit_n     = START_D;
                prescaler_n = '0;
                flag_n      = 1'b0;
                if (armed) begin
                    if (START_VAL == 0) begin
                        fsm_n   = DONE;
                        flag_n  = 1'b1;
                        digit_n = 4'd0;
                    end else begin
                        fsm_n = RUN;
                    end
                end
            end
            RUN: begin
                if (!armed) begin
                    fsm_n       = IDLE;
                    digit_n     = START_D;
                    prescaler_n = '0;
                    flag_n      = 1'b0;
                end else if (prescaler == PRE_MAX) begin
                    prescaler_n = '0;
                    tick_n      = 1'b1;
                    // Reaching 0 (or already there) ends the run; never wrap below 0.
                    if (current_digit <= 4'd1) begin
                        digit_n = 4'd0;
                        fsm_n   = DONE;
                        flag_n  = 1'b1;
                    end else begin
                        digit_n = current_digit - 4'd1;
                    end
                end else begin
                    prescaler_n = prescaler + 1'b1;
                end
            end
            DONE: begin
                digit_n = 4'd0;
                flag_n  = 1'b1;
                if (!armed) begin
                    fsm_n       = IDLE;
                    digit_n     = START_D;
                    flag_n      = 1'b0;
                    prescaler_n = '0;
                end
            end
            default: begin
                fsm_n       = IDLE;
                digit_n     = START_D;
                prescaler_n = '0;
                flag_n      = 1'b0;
            end
        endcase
        running_n = (fsm_n == RUN);
    end

    // Active-high {g,f,e,d,c,b,a}; out-of-range values blank.
    always_comb begin
        case (current_digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        hex = SEG_ACTIVE_LOW ? ~seg : seg;
    end

endmodule

// File: tb/tb_lock_countdown_timer.sv
// tb/tb_lock_countdown_timer.sv - directed self-checking bench for lock_countdown_timer
module tb_lock_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] state = 4'd0;
    logic [3:0] state_n = 4'd0;
    logic [3:0] state_z = 4'd0;

    logic [3:0] digit, digit_n, digit_z;
    logic       flag, flag_n, flag_z;
    logic       tick, tick_n, tick_z;
    logic       running, running_n, running_z;
    logic [6:0] hex, hex_n, hex_z;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lock_countdown_timer #(.TICK_DIV(4), .START_VAL(3), .RUN_STATE(4'b1011), .SEG_ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .reset(reset), .state(state), .current_digit(digit),
        .flag(flag), .tick(tick), .running(running), .hex(hex)
    );

    lock_countdown_timer #(.TICK_DIV(2), .START_VAL(9), .RUN_STATE(4'b1011), .SEG_ACTIVE_LOW(1'b1)) u_nine (
        .clk(clk), .reset(reset), .state(state_n), .current_digit(digit_n),
        .flag(flag_n), .tick(tick_n), .running(running_n), .hex(hex_n)
    );

    lock_countdown_timer #(.TICK_DIV(4), .START_VAL(0), .RUN_STATE(4'b1011), .SEG_ACTIVE_LOW(1'b1)) u_zero (
        .clk(clk), .reset(reset), .state(state_z), .current_digit(digit_z),
        .flag(flag_z), .tick(tick_z), .running(running_z), .hex(hex_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        check("rst_digit", 32'(digit), 32'd3);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("hex_3", 32'(hex), 32'(7'b0110000));
        check("hex_9", 32'(hex_n), 32'(7'b0010000));
        check("rst_zero_digit", 32'(digit_z), 32'd0);
        check("hex_0", 32'(hex_z), 32'(7'b1000000));
        check("rst_zero_flag", 32'(flag_z), 32'd0);

        reset = 1'b0;
        step();
        check("idle_running", 32'(running), 32'd0);

        // T1 full run
        state = 4'b1011;
        step();
        check("t1_entry_running", 32'(running), 32'd1);
        check("t1_entry_digit", 32'(digit), 32'd3);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t1_digit", 32'(digit), 32'(3 - k / 4));
            check("t1_tick", 32'(tick), 32'((k % 4) == 0));
            check("t1_flag", 32'(flag), 32'(k >= 12));
            check("t1_running", 32'(running), 32'(k < 12));
        end
        check("hex_0_done", 32'(hex), 32'(7'b1000000));

        // T3 hold, release, re-arm
        for (int i = 0; i < 100; i++) begin
            step();
            check("t3_hold_flag", 32'(flag), 32'd1);
            check("t3_hold_digit", 32'(digit), 32'd0);
            check("t3_hold_tick", 32'(tick), 32'd0);
        end
        state = 4'b1111;
        step();
        check("t3_release_flag", 32'(flag), 32'd0);
        check("t3_release_digit", 32'(digit), 32'd3);
        state = 4'b1011;
        step();
        check("t3_rearm_running", 32'(running), 32'd1);
        step();
        step();
        step();
        check("t3_rearm_digit_e3", 32'(digit), 32'd3);
        step();
        check("t3_rearm_digit_e4", 32'(digit), 32'd2);
        check("t3_rearm_tick", 32'(tick), 32'd1);

        // T2 abort with digit=2
        state = 4'b1010;
        step();
        check("t2_digit", 32'(digit), 32'd3);
        check("t2_flag", 32'(flag), 32'd0);
        check("t2_running", 32'(running), 32'd0);
        check("t2_tick", 32'(tick), 32'd0);
        step();
        check("t2_tick_after", 32'(tick), 32'd0);

        // T4 reset mid-run at digit=2, prescaler=2
        state = 4'b1011;
        step();
        for (int k = 1; k <= 6; k++) step();
        check("t4_pre_digit", 32'(digit), 32'd2);
        reset = 1'b1;
        step();
        check("t4_rst_digit", 32'(digit), 32'd3);
        check("t4_rst_flag", 32'(flag), 32'd0);
        check("t4_rst_tick", 32'(tick), 32'd0);
        check("t4_rst_running", 32'(running), 32'd0);
        reset = 1'b0;
        step();
        check("t4_reentry_running", 32'(running), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t4_wait_digit", 32'(digit), 32'd3);
        end
        step();
        check("t4_first_dec", 32'(digit), 32'd2);
        check("t4_first_tick", 32'(tick), 32'd1);
        state = 4'b0000;

        // T5 hex of digit 8 on the START_VAL=9 instance
        state_n = 4'b1011;
        step();
        step();
        check("t5_nine_e1", 32'(digit_n), 32'd9);
        step();
        check("t5_nine_digit", 32'(digit_n), 32'd8);
        check("hex_8", 32'(hex_n), 32'(7'b0000000));
        state_n = 4'b0000;

        // T6 START_VAL=0 variant
        state_z = 4'b1011;
        step();
        check("t6_flag", 32'(flag_z), 32'd1);
        check("t6_digit", 32'(digit_z), 32'd0);
        check("t6_tick", 32'(tick_z), 32'd0);
        check("t6_running", 32'(running_z), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t6_hold_tick", 32'(tick_z), 32'd0);
            check("t6_hold_digit", 32'(digit_z), 32'd0);
            check("t6_hold_flag", 32'(flag_z), 32'd1);
        end
        state_z = 4'b0000;
        step();
        check("t6_release_flag", 32'(flag_z), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
